ps2_rx: RTL and testbench

//  PS/2 keyboard receiver. Sits directly upstream of keyboard_ctrl.

---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_clk_filter.sv | 58 +++++
 rtl/ps2_rx.sv | 121 ++++++++++++
 tb/tb_ps2_rx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: constants and state encoding shared by the PS/2 receive path
// (ps2_rx, ps2_clk_filter) and keyboard_ctrl.
//   ps2_state_t   receiver FSM states
//   PS2_BREAK     break prefix byte (0xF0)
//   PS2_EXT       extended-code prefix byte (0xE0)
//   PS2_DATA_BITS data bits per frame
//   odd_par_ok()  1 when data plus parity bit holds an odd number of ones
package ps2_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} ps2_state_t;

  localparam logic [7:0] PS2_BREAK     = 8'hF0;
  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam int         PS2_DATA_BITS = 8;

  function automatic logic odd_par_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction
endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: brings kb_clk / kb_data into the clk domain and debounces
// the keyboard clock.
//   clk, rst    system clock, async active-low reset
//   kb_clk      raw PS/2 clock (async, idle high)
//   kb_data     raw PS/2 data  (async, idle high)
//   fall_tick   1-cycle pulse on a 1->0 transition of the filtered clock
//   data_sync   synchronised kb_data, sampled by the FSM on fall_tick
module ps2_clk_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic kb_clk,
  input  logic kb_data,
  output logic fall_tick,
  output logic data_sync
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] clk_sr, data_sr;
  logic                   clk_s, filt;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sr  <= '1;
      data_sr <= '1;
    end else begin
      clk_sr  <= {clk_sr[SYNC_STAGES-2:0], kb_clk};
      data_sr <= {data_sr[SYNC_STAGES-2:0], kb_data};
    end
  end

  assign clk_s     = clk_sr[SYNC_STAGES-1];
  assign data_sync = data_sr[SYNC_STAGES-1];

  // cnt tracks how many consecutive samples have disagreed with filt; any
  // agreeing sample restarts the run, so short glitches never get through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt      <= 1'b1;
      cnt       <= '0;
      fall_tick <= 1'b0;
    end else begin
      fall_tick <= 1'b0;
      if (clk_s == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt      <= clk_s;
        cnt       <= '0;
        fall_tick <= filt;  // old value 1 means this change is a fall
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 keyboard receiver. Deserialises 11-bit frames (start, 8 data
// LSB first, odd parity, stop) and hands checked bytes to keyboard_ctrl.
//   clk, rst       system clock, async active-low reset
//   kb_clk         PS/2 clock from keyboard (async, idle high)
//   kb_data        PS/2 data from keyboard (async, idle high)
//   scan_code_out  last good byte, held until the next good frame
//   valid_code     1-cycle pulse, scan_code_out updated
//   parity_err     1-cycle pulse, frame dropped on bad parity
//   frame_err      1-cycle pulse, frame dropped on bad stop bit or timeout
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kb_clk,
  input  logic       kb_data,
  output logic [7:0] scan_code_out,
  output logic       valid_code,
  output logic       parity_err,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic                     fall, data_s;
  ps2_state_t               state, state_nxt;
  logic [2:0]               bit_cnt;
  logic [PS2_DATA_BITS-1:0] shreg;
  logic                     par_q;
  logic [TW-1:0]            tcnt;
  logic                     good_nxt, perr_nxt, ferr_nxt, timeout;

  ps2_clk_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filt (
    .clk      (clk),
    .rst      (rst),
    .kb_clk   (kb_clk),
    .kb_data  (kb_data),
    .fall_tick(fall),
    .data_sync(data_s)
  );

  // A fall in the same cycle as the timeout wins.
  assign timeout = (state != ST_IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    good_nxt  = 1'b0;
    perr_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    unique case (state)
      ST_IDLE:   if (fall && !data_s) state_nxt = ST_DATA;
      ST_DATA:   if (fall && bit_cnt == 3'(PS2_DATA_BITS - 1)) state_nxt = ST_PARITY;
      ST_PARITY: if (fall) state_nxt = ST_STOP;
      ST_STOP: begin
        if (fall) begin
          state_nxt = ST_IDLE;
          if (!data_s)                       ferr_nxt = 1'b1;
          else if (odd_par_ok(shreg, par_q)) good_nxt = 1'b1;
          else                               perr_nxt = 1'b1;
        end
      end
    endcase
    if (timeout) begin
      state_nxt = ST_IDLE;
      ferr_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
    end else if (fall) begin
      unique case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          shreg   <= '0;
        end
        ST_DATA: begin
          shreg[bit_cnt] <= data_s;
          bit_cnt        <= bit_cnt + 3'd1;
        end
        ST_PARITY: par_q <= data_s;
        ST_STOP:   ;
      endcase
    end
  end

  // Idle-time counter: held at 0 outside a frame, saturating inside one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            tcnt <= '0;
    else if (state_nxt == ST_IDLE || fall) tcnt <= '0;
    else if (tcnt != '1)                 tcnt <= tcnt + TW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_code_out <= '0;
      valid_code    <= 1'b0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      valid_code <= good_nxt;
      parity_err <= perr_nxt;
      frame_err  <= ferr_nxt;
      if (good_nxt) scan_code_out <= shreg;
    end
  end
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: self-checking bench for ps2_rx. Keyboard timing is scaled down
// (kb_clk half period HALF clk cycles, short timeout) so the run stays small.
module tb_ps2_rx;
  localparam int HALF = 40;
  localparam int TO   = 300;
  localparam logic [1:0] EV_V = 2'd0, EV_P = 2'd1, EV_F = 2'd2;

  logic       clk = 1'b0, rst = 1'b0, kb_clk = 1'b1, kb_data = 1'b1;
  logic [7:0] scan_code_out;
  logic       valid_code, parity_err, frame_err;

  always #5 clk = ~clk;

  ps2_rx #(.SYNC_STAGES(2), .FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .kb_clk(kb_clk), .kb_data(kb_data),
    .scan_code_out(scan_code_out), .valid_code(valid_code),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  typedef struct { logic [1:0] kind; logic [7:0] code; } ev_t;
  typedef struct { logic [7:0] d; logic pf; logic sb; logic [1:0] kind; logic [7:0] scan; } vec_t;

  ev_t evq[$];
  int  checks = 0, errors = 0;

  // Record every output pulse; more than one at once is a failure by itself.
  always @(negedge clk) begin
    if (rst) begin
      if ((32'(valid_code) + 32'(parity_err) + 32'(frame_err)) > 1) begin
        errors++;
        $display("FAIL pulse_exclusive: got v=%0b p=%0b f=%0b expected at most one",
                 valid_code, parity_err, frame_err);
      end
      if (valid_code) evq.push_back('{EV_V, scan_code_out});
      if (parity_err) evq.push_back('{EV_P, 8'h00});
      if (frame_err)  evq.push_back('{EV_F, 8'h00});
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Data changes mid-high, then a full low half period, then back high.
  task automatic send_bit(input logic b, input logic glitch);
    kb_data = b;
    wait_clks(HALF / 2);
    kb_clk = 1'b0;
    wait_clks(HALF);
    kb_clk = 1'b1;
    if (glitch) begin
      wait_clks(5);
      kb_clk = 1'b0;
      wait_clks(3);
      kb_clk = 1'b1;
      wait_clks(HALF / 2 - 8);
    end else begin
      wait_clks(HALF / 2);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pf, input logic sb,
                            input int glitch_bit, input int gap);
    logic [10:0] f;
    f = {~sb, (~^d) ^ pf, d, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i], i == glitch_bit);
    kb_data = 1'b1;
    wait_clks(gap);
  endtask

  task automatic expect_ev(input string name, input logic [1:0] kind, input logic [7:0] held);
    ev_t e;
    check({name, "_count"}, evq.size(), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      check({name, "_kind"}, e.kind, kind);
      if (kind == EV_V) check({name, "_code"}, e.code, held);
    end
    check({name, "_held"}, scan_code_out, held);
    evq.delete();
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_scan"},  scan_code_out, 0);
    check({name, "_valid"}, valid_code, 0);
    check({name, "_perr"},  parity_err, 0);
    check({name, "_ferr"},  frame_err, 0);
  endtask

  initial begin
    vec_t       vt[10];
    logic [7:0] held, d;
    logic       pf, sb, p;
    logic [1:0] kind;
    int         gb;

    vt[0] = '{8'h1C, 1'b0, 1'b0, EV_V, 8'h1C};
    vt[1] = '{8'hF0, 1'b0, 1'b0, EV_V, 8'hF0};
    vt[2] = '{8'h1C, 1'b0, 1'b0, EV_V, 8'h1C};
    vt[3] = '{8'h1C, 1'b1, 1'b0, EV_P, 8'h1C};
    vt[4] = '{8'h2B, 1'b0, 1'b1, EV_F, 8'h1C};
    vt[5] = '{8'h2B, 1'b0, 1'b0, EV_V, 8'h2B};
    vt[6] = '{8'hE0, 1'b0, 1'b0, EV_V, 8'hE0};
    vt[7] = '{8'h00, 1'b1, 1'b0, EV_P, 8'hE0};
    vt[8] = '{8'hFF, 1'b0, 1'b1, EV_F, 8'hE0};
    vt[9] = '{8'h00, 1'b1, 1'b1, EV_F, 8'hE0};

    wait_clks(4);
    check_reset_outs("reset");
    rst = 1'b1;
    wait_clks(HALF);

    for (int i = 0; i < 10; i++) begin
      send_frame(vt[i].d, vt[i].pf, vt[i].sb, -1, HALF);
      expect_ev($sformatf("vec%0d", i), vt[i].kind, vt[i].scan);
    end

    // Back-to-back: no idle gap between frames.
    send_frame(8'h1C, 1'b0, 1'b0, -1, 0);
    send_frame(PS2_F0(), 1'b0, 1'b0, -1, 0);
    send_frame(8'h1C, 1'b0, 1'b0, -1, HALF);
    check("b2b_count", evq.size(), 3);
    for (int i = 0; i < 3 && evq.size() > 0; i++) begin
      ev_t e;
      e = evq.pop_front();
      check($sformatf("b2b%0d_kind", i), e.kind, EV_V);
      check($sformatf("b2b%0d_code", i), e.code, (i == 1) ? 8'hF0 : 8'h1C);
    end
    evq.delete();

    // Spurious start (data high on the first fall) is ignored silently.
    send_bit(1'b1, 1'b0);
    wait_clks(HALF);
    check("spurious_count", evq.size(), 0);

    // Timeout: start plus 5 bits, then the clock stops.
    for (int i = 0; i < 6; i++) send_bit(i == 0 ? 1'b0 : 1'b1, 1'b0);
    kb_data = 1'b1;
    wait_clks(TO + 100);
    expect_ev("timeout", EV_F, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0, -1, HALF);
    expect_ev("after_to", EV_V, 8'h1C);

    // Short low glitch on kb_clk mid-frame must not add a bit.
    send_frame(8'hA5, 1'b0, 1'b0, 4, HALF);
    expect_ev("glitch", EV_V, 8'hA5);

    // Reset mid-frame: partial frame dropped without any error pulse.
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
    rst = 1'b0;
    kb_data = 1'b1;
    wait_clks(3);
    check_reset_outs("midrst");
    rst = 1'b1;
    wait_clks(HALF);
    check("midrst_noev", evq.size(), 0);
    send_frame(8'h1C, 1'b0, 1'b0, -1, HALF);
    expect_ev("after_rst", EV_V, 8'h1C);

    // Random frames against a rule-level model of the frame checks.
    held = 8'h1C;
    for (int n = 0; n < 30; n++) begin
      d  = 8'($urandom);
      pf = ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 4) == 0);
      gb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1;
      p  = (($countones(d) % 2) == 0) ^ pf;  // parity bit actually sent
      if (sb)                                  kind = EV_F;
      else if (($countones({d, p}) % 2) == 1) kind = EV_V;
      else                                     kind = EV_P;
      if (kind == EV_V) held = d;
      send_frame(d, pf, sb, gb, HALF);
      expect_ev($sformatf("rnd%0d", n), kind, held);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [7:0] PS2_F0();
    return 8'hF0;
  endfunction
endmodule
